// File: rtl/sx_bus_ctrl.sv
// Bus controller for a 16-bit CPU: decodes ROM / RAM / I/O / special cycles and paces READY#.
// Optional POST-code capture on I/O port 0x80 is enabled with SX_BUS_CTRL_POST_CAPTURE_EN.
module sx_bus_ctrl #(
    parameter int          ROM_WS  = 1,
    parameter int          RAM_WS  = 1,
    parameter int          IO_WS   = 2,
    parameter int          TIMEOUT = 15,
    parameter int          ROM_AW  = 9,
    parameter logic [23:0] RAM_TOP = 24'h800000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ads_n,
    input  logic              w_r,
    input  logic              d_c,
    input  logic              m_io,
    input  logic [1:0]        be_n,
    input  logic [22:0]       addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              cpu_doe,
    output logic              ready_n,
    output logic              na_n,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [15:0]       rom_rdata,
    output logic [21:0]       ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [1:0]        ram_be,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic              bus_err,
    output logic [7:0]        post_code
);

    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACK} state_t;
    typedef enum logic [2:0] {RG_ROM, RG_RAM, RG_IO, RG_SPEC, RG_UNMAP} region_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    region_t         region_d, region_p0;
    logic [CW-1:0]   ws_d, ws_p0;
    logic [21:0]     addr_p0;
    logic [1:0]      be_n_p0;
    logic            w_r_p0;
    logic [15:0]     din_p0;
    logic [15:0]     cpu_dout_r;
    logic            ack_entry;

    // Address decode; port addr carries A[23:1], so A[k] is addr[k-1].
    logic [23:0] byte_addr;
    logic        alias_ok, is_mem, is_spec, hit_rom, hit_rsv, hit_ram;

    assign byte_addr = {addr, 1'b0};
    assign alias_ok  = (&addr[22:19]) || (~|addr[22:19]);
    assign is_mem    = ~m_io;
    assign is_spec   = m_io & ~d_c & w_r;
    assign hit_rom   = is_mem & alias_ok & (&addr[18:ROM_AW]);
    assign hit_rsv   = is_mem & alias_ok & (&addr[18:15]) & ~hit_rom;
    assign hit_ram   = is_mem & (byte_addr < RAM_TOP) & ~hit_rom & ~hit_rsv;

    always_comb begin
        region_d = RG_UNMAP;
        ws_d     = CW'(TIMEOUT);
        if (is_spec) begin
            region_d = RG_SPEC;
            ws_d     = '0;
        end else if (m_io) begin
            region_d = RG_IO;
            ws_d     = CW'(IO_WS);
        end else if (hit_rom) begin
            region_d = RG_ROM;
            ws_d     = CW'(ROM_WS);
        end else if (hit_ram) begin
            region_d = RG_RAM;
            ws_d     = CW'(RAM_WS);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!ads_n) state_nx = ADDR;
            ADDR:    state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ack_entry = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset_n)                        cnt <= '0;
        else if (state == ADDR)              cnt <= ws_p0;
        else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Request latch on the ads_n sample edge; data only, so no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && !ads_n) begin
            addr_p0   <= addr[21:0];
            be_n_p0   <= be_n;
            w_r_p0    <= w_r;
            din_p0    <= cpu_din;
            region_p0 <= region_d;
            ws_p0     <= ws_d;
        end
    end

    // Memories have one-cycle latency, so data is stable by the WAIT->ACK edge even with WS=0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cpu_dout_r <= '0;
        end else if (ack_entry && !w_r_p0) begin
            case (region_p0)
                RG_ROM:   cpu_dout_r <= rom_rdata;
                RG_RAM:   cpu_dout_r <= ram_rdata;
                RG_IO:    cpu_dout_r <= 16'hFFFF;
                RG_UNMAP: cpu_dout_r <= 16'hFFFF;
                default:  cpu_dout_r <= cpu_dout_r;
            endcase
        end
    end

`ifdef SX_BUS_CTRL_POST_CAPTURE_EN
    logic [7:0] post_code_r;

    always_ff @(posedge clk) begin
        if (!reset_n)
            post_code_r <= '0;
        else if (ack_entry && region_p0 == RG_IO && w_r_p0 &&
                 addr_p0 == 22'h40 && !be_n_p0[0])
            post_code_r <= din_p0[7:0];
    end

    assign post_code = post_code_r;
`else
    assign post_code = 8'h00;
`endif

    assign cpu_dout  = cpu_dout_r;
    assign ready_n   = (state != ACK);
    assign na_n      = 1'b1;
    assign cpu_doe   = (state == ACK) && !w_r_p0;
    assign bus_err   = (state == ACK) && (region_p0 == RG_UNMAP);
    assign rom_rd    = (state == ADDR) && (region_p0 == RG_ROM) && !w_r_p0;
    assign ram_rd    = (state == ADDR) && (region_p0 == RG_RAM) && !w_r_p0;
    assign ram_wr    = (state == ADDR) && (region_p0 == RG_RAM) &&  w_r_p0;
    assign rom_addr  = addr_p0[ROM_AW-1:0];
    assign ram_addr  = addr_p0;
    assign ram_be    = ~be_n_p0;
    assign ram_wdata = din_p0;

endmodule

// File: tb/tb_sx_bus_ctrl.sv
// Directed, table-driven bench for sx_bus_ctrl with default parameters.
`timescale 1ns/1ps
module tb_sx_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, ads_n, w_r, d_c, m_io;
    logic [1:0]  be_n;
    logic [22:0] addr;
    logic [15:0] cpu_din, cpu_dout, rom_rdata, ram_rdata, ram_wdata;
    logic        cpu_doe, ready_n, na_n, rom_rd, ram_rd, ram_wr, bus_err;
    logic [8:0]  rom_addr;
    logic [21:0] ram_addr;
    logic [1:0]  ram_be;
    logic [7:0]  post_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sx_bus_ctrl dut (
        .clk(clk), .reset_n(reset_n), .ads_n(ads_n), .w_r(w_r), .d_c(d_c), .m_io(m_io),
        .be_n(be_n), .addr(addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_doe(cpu_doe),
        .ready_n(ready_n), .na_n(na_n), .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_rdata(rom_rdata), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .bus_err(bus_err),
        .post_code(post_code)
    );

    // exp_strb: 0 none, 1 rom_rd, 2 ram_rd, 3 ram_wr
    typedef struct {
        logic        w_r, d_c, m_io;
        logic [1:0]  be_n;
        logic [22:0] addr;
        logic [15:0] din, ram_d;
        int          exp_ack, exp_strb;
        logic [21:0] exp_maddr;
        logic [1:0]  exp_be;
        logic [15:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp_v);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n_rom = 0, n_rrd = 0, n_rwr = 0, n_err = 0, ack_cyc = 0;
        logic [21:0] s_addr = '0;
        logic [1:0]  s_be = '0;
        logic [15:0] s_wd = '0, s_dout = '0;
        logic        s_doe = 1'b0;
        @(negedge clk);
        w_r = v.w_r; d_c = v.d_c; m_io = v.m_io; be_n = v.be_n;
        addr = v.addr; cpu_din = v.din; ram_rdata = v.ram_d; ads_n = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 40 && ack_cyc == 0; c++) begin
            @(negedge clk);
            if (rom_rd) begin n_rom++; s_addr = {13'd0, rom_addr}; end
            if (ram_rd) begin n_rrd++; s_addr = ram_addr; s_be = ram_be; end
            if (ram_wr) begin n_rwr++; s_addr = ram_addr; s_be = ram_be; s_wd = ram_wdata; end
            if (bus_err) n_err++;
            if (!ready_n) begin ack_cyc = c; s_dout = cpu_dout; s_doe = cpu_doe; end
            if (c == 1) begin
                ads_n = 1'b1; addr = ~v.addr; cpu_din = ~v.din; be_n = ~v.be_n; w_r = ~v.w_r;
            end
        end
        @(negedge clk);
        chk("ack_one_cycle", idx, 32'(ready_n), 32'd1);
        chk("ack_cycle", idx, ack_cyc, v.exp_ack);
        chk("rom_rd_cnt", idx, n_rom, (v.exp_strb == 1) ? 1 : 0);
        chk("ram_rd_cnt", idx, n_rrd, (v.exp_strb == 2) ? 1 : 0);
        chk("ram_wr_cnt", idx, n_rwr, (v.exp_strb == 3) ? 1 : 0);
        chk("bus_err_cnt", idx, n_err, 32'(v.exp_err));
        chk("cpu_doe", idx, 32'(s_doe), 32'(!v.w_r));
        if (v.exp_strb != 0) chk("mem_addr", idx, 32'(s_addr), 32'(v.exp_maddr));
        if (v.exp_strb >= 2) chk("ram_be", idx, 32'(s_be), 32'(v.exp_be));
        if (v.exp_strb == 3) chk("ram_wdata", idx, 32'(s_wd), 32'(v.din));
        if (!v.w_r) chk("cpu_dout", idx, 32'(s_dout), 32'(v.exp_dout));
    endtask

    task automatic chk_reset_vals(input int idx);
        chk("rst_ready_n", idx, 32'(ready_n), 32'd1);
        chk("rst_na_n", idx, 32'(na_n), 32'd1);
        chk("rst_doe", idx, 32'(cpu_doe), 32'd0);
        chk("rst_strobes", idx, {29'd0, rom_rd, ram_rd, ram_wr}, 32'd0);
        chk("rst_bus_err", idx, 32'(bus_err), 32'd0);
        chk("rst_cpu_dout", idx, 32'(cpu_dout), 32'd0);
        chk("rst_post_code", idx, 32'(post_code), 32'd0);
    endtask

    initial begin
        int n_ack, n_strb;
        logic [7:0] exp_post;
`ifdef SX_BUS_CTRL_POST_CAPTURE_EN
        exp_post = 8'h42;
`else
        exp_post = 8'h00;
`endif
        rom_rdata = 16'hC3A5;
        //            w_r d_c m_io be_n  addr        din       ram_d     ack strb maddr        be     dout      err
        vecs[0]  = '{1'b0,1'b1,1'b0,2'b00,23'h7FFFF8,16'h0000,16'h0000, 4, 1, 22'h1F8,    2'b00, 16'hC3A5, 1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,2'b00,23'h07FFF8,16'h0000,16'h0000, 4, 1, 22'h1F8,    2'b00, 16'hC3A5, 1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,2'b00,23'h7F8000,16'h0000,16'h0000,18, 0, 22'h0,      2'b00, 16'hFFFF, 1'b1};
        vecs[3]  = '{1'b1,1'b1,1'b0,2'b10,23'h000080,16'hA55A,16'h0000, 4, 3, 22'h80,     2'b01, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,2'b00,23'h00091A,16'h0000,16'h5A5A, 4, 2, 22'h91A,    2'b11, 16'h5A5A, 1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b1,2'b10,23'h000040,16'h0042,16'h0000, 5, 0, 22'h0,      2'b00, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b1,2'b00,23'h000030,16'h0000,16'h0000, 5, 0, 22'h0,      2'b00, 16'hFFFF, 1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b1,2'b00,23'h000001,16'h0000,16'h0000, 3, 0, 22'h0,      2'b00, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,2'b00,23'h7FFFF8,16'h1111,16'h0000, 4, 0, 22'h0,      2'b00, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,2'b00,23'h3FFFFF,16'h0000,16'h9669, 4, 2, 22'h3FFFFF, 2'b11, 16'h9669, 1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,2'b00,23'h400000,16'h0000,16'h0000,18, 0, 22'h0,      2'b00, 16'hFFFF, 1'b1};
        vecs[11] = '{1'b1,1'b1,1'b0,2'b00,23'h078000,16'h7777,16'h0000,18, 0, 22'h0,      2'b00, 16'h0000, 1'b1};

        reset_n = 1'b0; ads_n = 1'b1; w_r = 1'b0; d_c = 1'b1; m_io = 1'b0;
        be_n = 2'b11; addr = '0; cpu_din = '0; ram_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals(0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        @(negedge clk);
        chk("post_code", 0, 32'(post_code), 32'(exp_post));

        // Second ads_n strobes while the first cycle is still waiting.
        @(negedge clk);
        w_r = 1'b0; d_c = 1'b1; m_io = 1'b1; be_n = 2'b00; addr = 23'h30; ads_n = 1'b0;
        @(posedge clk);
        n_ack = 0; n_strb = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!ready_n) n_ack++;
            if (rom_rd || ram_rd || ram_wr) n_strb++;
            if (c == 1) ads_n = 1'b1;
            if (c == 2 || c == 3) begin
                ads_n = 1'b0; m_io = 1'b0; w_r = 1'b1; addr = 23'h100;
            end
            if (c == 4) ads_n = 1'b1;
        end
        chk("dbl_ads_acks", 0, n_ack, 1);
        chk("dbl_ads_strobes", 0, n_strb, 0);

        // Reset while a RAM read sits in WAIT.
        @(negedge clk);
        w_r = 1'b0; d_c = 1'b1; m_io = 1'b0; be_n = 2'b00; addr = 23'h100;
        ram_rdata = 16'h1357; ads_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ads_n = 1'b1;
        chk("abort_ram_rd_seen", 1, 32'(ram_rd), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals(1);
        reset_n = 1'b1;
        n_ack = 0; n_strb = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!ready_n) n_ack++;
            if (rom_rd || ram_rd || ram_wr) n_strb++;
        end
        chk("abort_no_ack", 1, n_ack, 0);
        chk("abort_no_strobe", 1, n_strb, 0);
        run_vec(12, vecs[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
